// File: rtl/put_controller.sv
// put_controller: write-side control for a FIFO. Tracks the write pointer
// and occupancy, produces the storage write enable, and keeps a sticky
// overflow flag for puts rejected while the FIFO is full. No storage here.
module put_controller #(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_put,
    input  logic              en_get,
    input  logic              clear_ovf,
    output logic              en_put,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_C = (ADDR_W+1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

    logic get_eff;

    // Write enable and effective pop; reset gates the enable so nothing commits while held
    always_comb begin
        en_put  = req_put && !full && !reset;
        get_eff = en_get && (count != '0);
    end

    // Status flags decode only the registered count, never same-cycle inputs
    always_comb begin
        full        = (count == DEPTH_C);
        empty       = (count == '0);
        almost_full = (count >= AFULL_C);
    end

    // Write pointer advances on every committed put; power-of-two depth wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr <= '0;
        end else if (en_put) begin
            wr_addr <= wr_addr + ADR_ONE;
        end
    end

    // Occupancy: put and pop in the same cycle cancel out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({en_put, get_eff})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a rejected put on the same edge as a clear keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (req_put && full) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_put_controller.sv
// tb_put_controller: scoreboard bench for put_controller. A reference model
// predicts the post-edge state as each stimulus is driven; the prediction is
// queued and compared against the DUT after the edge.
module tb_put_controller;

    localparam int DEPTH = 8;

    logic       clk;
    logic       reset;
    logic       req_put;
    logic       en_get;
    logic       clear_ovf;
    logic       en_put;
    logic [2:0] wr_addr;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       overflow;

    typedef struct {
        int cnt;
        int addr;
        int ovf;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    int m_count = 0;
    int m_addr  = 0;
    int m_ovf   = 0;

    put_controller #(.DEPTH(8), .ADDR_W(3), .AFULL_THRESH(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_put     (req_put),
        .en_get      (en_get),
        .clear_ovf   (clear_ovf),
        .en_put      (en_put),
        .wr_addr     (wr_addr),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Compare every DUT output against a predicted state
    task automatic compareState(input string tag, input exp_t e);
        checkOutput({tag, ".count"}, int'(count), e.cnt);
        checkOutput({tag, ".wr_addr"}, int'(wr_addr), e.addr);
        checkOutput({tag, ".overflow"}, int'(overflow), e.ovf);
        checkOutput({tag, ".full"}, int'(full), (e.cnt == DEPTH) ? 1 : 0);
        checkOutput({tag, ".empty"}, int'(empty), (e.cnt == 0) ? 1 : 0);
        checkOutput({tag, ".almost_full"}, int'(almost_full), (e.cnt >= 6) ? 1 : 0);
    endtask

    // Drive one cycle of inputs, predict en_put and the next state, then check after the edge
    task automatic applyStimulus(input string tag, input bit req, input bit get, input bit clr);
        exp_t e;
        bit   put_ok;
        bit   get_ok;
        @(negedge clk);
        req_put   = req;
        en_get    = get;
        clear_ovf = clr;
        #1;
        put_ok = req && (m_count != DEPTH);
        get_ok = get && (m_count != 0);
        checkOutput({tag, ".en_put"}, int'(en_put), int'(put_ok));
        if (req && (m_count == DEPTH)) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (put_ok && !get_ok) m_count++;
        else if (get_ok && !put_ok) m_count--;
        if (put_ok) m_addr = (m_addr + 1) % DEPTH;
        e.cnt  = m_count;
        e.addr = m_addr;
        e.ovf  = m_ovf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput({tag, ".queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            compareState(tag, e);
        end
    endtask

    task automatic modelReset();
        m_count = 0;
        m_addr  = 0;
        m_ovf   = 0;
        exp_q.delete();
    endtask

    initial begin
        exp_t zero;
        zero.cnt  = 0;
        zero.addr = 0;
        zero.ovf  = 0;

        reset     = 1'b1;
        req_put   = 1'b1;
        en_get    = 1'b0;
        clear_ovf = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        compareState("reset", zero);
        checkOutput("reset.en_put", int'(en_put), 0);

        @(negedge clk);
        reset   = 1'b0;
        req_put = 1'b0;

        // Fill from empty to full
        for (int i = 0; i < 8; i++) applyStimulus("fill", 1, 0, 0);

        // Put while full with a simultaneous get: put dropped, get taken, overflow set
        applyStimulus("full_block", 1, 1, 0);

        // Drain to 3, then stream put+get for 10 cycles
        for (int i = 0; i < 4; i++) applyStimulus("drain", 0, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus("stream", 1, 1, 0);

        // Clear overflow while not full
        applyStimulus("ovf_clear", 0, 0, 1);
        applyStimulus("ovf_idle", 0, 0, 0);

        // Refill to full, then rejected put coinciding with clear: set wins
        for (int i = 0; i < 5; i++) applyStimulus("refill", 1, 0, 0);
        applyStimulus("set_wins", 1, 0, 1);
        applyStimulus("clear_after", 0, 0, 1);

        // Underflow from reset
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("underflow", 0, 1, 0);

        // Mid-run asynchronous reset with five entries held
        for (int i = 0; i < 5; i++) applyStimulus("prefill", 1, 0, 0);
        #2;
        reset   = 1'b1;
        req_put = 1'b1;
        #1;
        modelReset();
        compareState("async_reset", zero);
        checkOutput("async_reset.en_put", int'(en_put), 0);
        @(negedge clk);
        reset   = 1'b0;
        req_put = 1'b0;
        #1;
        checkOutput("post_reset.wr_addr", int'(wr_addr), 0);
        applyStimulus("post_reset_put", 1, 0, 0);

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            applyStimulus("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0));
        end

        checkOutput("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
